// File: rtl/axi4lite_regfile.sv
// AXI4-Lite slave register file with read-only ID word at register 0.
// Optional: define AXIL_REGFILE_DECERR_EN for DECERR/SLVERR responses.
module axi4lite_regfile #(
    parameter int                     ADDR_WIDTH  = 32,
    parameter int                     DATA_WIDTH  = 32,
    parameter int                     NUM_REGS    = 16,
    parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR   = '0,
    parameter logic [31:0]            ID_VALUE    = 32'hA11E_0001,
    parameter logic [DATA_WIDTH-1:0]  RESET_VALUE = '0
) (
    input  logic                           aclk,
    input  logic                           aresetn,
    input  logic [ADDR_WIDTH-1:0]          s_axi_awaddr,
    input  logic [2:0]                     s_axi_awprot,
    input  logic                           s_axi_awvalid,
    output logic                           s_axi_awready,
    input  logic [DATA_WIDTH-1:0]          s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0]        s_axi_wstrb,
    input  logic                           s_axi_wvalid,
    output logic                           s_axi_wready,
    output logic [1:0]                     s_axi_bresp,
    output logic                           s_axi_bvalid,
    input  logic                           s_axi_bready,
    input  logic [ADDR_WIDTH-1:0]          s_axi_araddr,
    input  logic [2:0]                     s_axi_arprot,
    input  logic                           s_axi_arvalid,
    output logic                           s_axi_arready,
    output logic [DATA_WIDTH-1:0]          s_axi_rdata,
    output logic [1:0]                     s_axi_rresp,
    output logic                           s_axi_rvalid,
    input  logic                           s_axi_rready,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
    output logic [NUM_REGS-1:0]            wr_pulse_o
);

    localparam int STRB_W   = DATA_WIDTH / 8;
    localparam int ADDR_LSB = $clog2(STRB_W);
    localparam int IDX_W    = ADDR_WIDTH - ADDR_LSB;
    localparam logic [IDX_W-1:0]      NREGS_IDX = IDX_W'(NUM_REGS);
    localparam logic [DATA_WIDTH-1:0] ID_WORD   = DATA_WIDTH'(ID_VALUE);

    logic                  aw_held_q, aw_held_d;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic                  w_held_q, w_held_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0]     wstrb_q, wstrb_d;
    logic                  awready_q, awready_d;
    logic                  wready_q, wready_d;
    logic                  bvalid_q, bvalid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic                  arready_q, arready_d;
    logic                  rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
    logic [NUM_REGS-1:0]   wr_pulse_q, wr_pulse_d;

    logic                  aw_hs, w_hs, ar_hs, b_hs, r_hs, commit;
    logic [ADDR_WIDTH-1:0] w_addr, w_off, r_off;
    logic [DATA_WIDTH-1:0] w_data;
    logic [STRB_W-1:0]     w_strb;
    logic [IDX_W-1:0]      w_idx, r_idx;
    logic                  w_inr, r_inr;

    assign aw_hs  = s_axi_awvalid && awready_q;
    assign w_hs   = s_axi_wvalid && wready_q;
    assign ar_hs  = s_axi_arvalid && arready_q;
    assign b_hs   = bvalid_q && s_axi_bready;
    assign r_hs   = rvalid_q && s_axi_rready;

    // A channel handshaking this cycle stands in for its holding register.
    assign w_addr = aw_hs ? s_axi_awaddr : awaddr_q;
    assign w_data = w_hs ? s_axi_wdata : wdata_q;
    assign w_strb = w_hs ? s_axi_wstrb : wstrb_q;
    assign commit = (aw_held_q || aw_hs) && (w_held_q || w_hs);

    assign w_off  = w_addr - BASE_ADDR;
    assign r_off  = s_axi_araddr - BASE_ADDR;
    assign w_idx  = w_off[ADDR_WIDTH-1:ADDR_LSB];
    assign r_idx  = r_off[ADDR_WIDTH-1:ADDR_LSB];
    assign w_inr  = w_idx < NREGS_IDX;
    assign r_inr  = r_idx < NREGS_IDX;

    logic unused_ok;
    assign unused_ok = ^{s_axi_awprot, s_axi_arprot,
                         w_off[ADDR_LSB-1:0], r_off[ADDR_LSB-1:0]};

    always_comb begin
        aw_held_d  = aw_held_q;
        awaddr_d   = awaddr_q;
        w_held_d   = w_held_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        regs_d     = regs_q;
        wr_pulse_d = '0;
        if (b_hs) bvalid_d = 1'b0;
        if (aw_hs) begin
            aw_held_d = 1'b1;
            awaddr_d  = s_axi_awaddr;
        end
        if (w_hs) begin
            w_held_d = 1'b1;
            wdata_d  = s_axi_wdata;
            wstrb_d  = s_axi_wstrb;
        end
        if (commit) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = 2'b00;
`ifdef AXIL_REGFILE_DECERR_EN
            if (!w_inr)
                bresp_d = 2'b11;
            else if (w_idx == '0)
                bresp_d = 2'b10;
`endif
            // Loop starts at 1 so the ID word can never be written.
            for (int i = 1; i < NUM_REGS; i++) begin
                if (w_inr && w_idx == IDX_W'(i)) begin
                    for (int b = 0; b < STRB_W; b++) begin
                        if (w_strb[b])
                            regs_d[i][8*b +: 8] = w_data[8*b +: 8];
                    end
                    wr_pulse_d[i] = |w_strb;
                end
            end
        end
        awready_d = !aw_held_d && !bvalid_d;
        wready_d  = !w_held_d && !bvalid_d;
    end

    always_comb begin
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        if (r_hs) rvalid_d = 1'b0;
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = '0;
            rresp_d  = 2'b00;
`ifdef AXIL_REGFILE_DECERR_EN
            if (!r_inr) rresp_d = 2'b11;
`endif
            for (int i = 0; i < NUM_REGS; i++) begin
                if (r_inr && r_idx == IDX_W'(i))
                    rdata_d = regs_q[i];
            end
        end
        arready_d = !rvalid_d;
    end

    always_ff @(posedge aclk or posedge aresetn) begin
        if (aresetn) begin
            aw_held_q  <= 1'b0;
            awaddr_q   <= '0;
            w_held_q   <= 1'b0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= 2'b00;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= 2'b00;
            wr_pulse_q <= '0;
            for (int i = 0; i < NUM_REGS; i++)
                regs_q[i] <= (i == 0) ? ID_WORD : RESET_VALUE;
        end else begin
            aw_held_q  <= aw_held_d;
            awaddr_q   <= awaddr_d;
            w_held_q   <= w_held_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            wr_pulse_q <= wr_pulse_d;
            regs_q     <= regs_d;
        end
    end

    always_comb begin
        regs_o = '0;
        for (int i = 0; i < NUM_REGS; i++)
            regs_o[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
    end

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = wready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;
    assign wr_pulse_o    = wr_pulse_q;

endmodule

// File: tb/tb_axi4lite_regfile.sv
// Bench for axi4lite_regfile: directed plan plus random traffic
// against a transaction-level register model.
module tb_axi4lite_regfile;

    localparam int          NR   = 16;
    localparam int          DW   = 32;
    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam logic [31:0] IDV  = 32'hA11E_0001;
    localparam logic [31:0] RV   = 32'h0000_0000;
`ifdef AXIL_REGFILE_DECERR_EN
    localparam bit DECERR = 1'b1;
`else
    localparam bit DECERR = 1'b0;
`endif

    logic          aclk = 1'b0;
    logic          rst  = 1'b0;
    logic [31:0]   awaddr, wdata, araddr, rdata;
    logic [2:0]    awprot, arprot;
    logic [3:0]    wstrb;
    logic          awvalid, awready, wvalid, wready;
    logic [1:0]    bresp, rresp;
    logic          bvalid, bready, arvalid, arready, rvalid, rready;
    logic [NR*DW-1:0] regs;
    logic [NR-1:0] pulse;

    always #5 aclk = ~aclk;

    axi4lite_regfile #(
        .ADDR_WIDTH(32), .DATA_WIDTH(DW), .NUM_REGS(NR),
        .BASE_ADDR(BASE), .ID_VALUE(IDV), .RESET_VALUE(RV)
    ) dut (
        .aclk(aclk), .aresetn(rst),
        .s_axi_awaddr(awaddr), .s_axi_awprot(awprot),
        .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb),
        .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid),
        .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arprot(arprot),
        .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp),
        .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .regs_o(regs), .wr_pulse_o(pulse)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 0;

    task automatic chk(input string nm, input logic [NR*DW-1:0] act,
                       input logic [NR*DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Transaction-level model: one word array plus pending-response state.
    logic [31:0] mreg [NR];
    bit          m_on, m_awh, m_wh, m_bv, m_rv;
    logic [31:0] m_awa, m_wd, m_rd, m_idx;
    logic [3:0]  m_ws;
    logic [1:0]  m_br, m_rr;
    logic [NR-1:0] m_pulse;
    bit          m_awr, m_wr, m_arr;

    function automatic logic [31:0] idx_of(input logic [31:0] a);
        return (a - BASE) / 4;
    endfunction

    initial forever begin
        @(posedge aclk or posedge rst);
        if (rst) begin
            for (int i = 0; i < NR; i++) mreg[i] = RV;
            m_on = 0; m_awh = 0; m_wh = 0; m_bv = 0; m_rv = 0;
            m_br = 0; m_rr = 0; m_rd = 0; m_pulse = '0;
        end else begin
            m_awr = m_on && !m_awh && !m_bv;
            m_wr  = m_on && !m_wh && !m_bv;
            m_arr = m_on && !m_rv;
            m_pulse = '0;
            if (m_rv && rready) m_rv = 0;
            if (arvalid && m_arr) begin
                m_idx = idx_of(araddr);
                m_rv  = 1;
                m_rd  = (m_idx == 0) ? IDV :
                        (m_idx < NR) ? mreg[m_idx] : 32'h0;
                m_rr  = (DECERR && m_idx >= NR) ? 2'b11 : 2'b00;
            end
            if (m_bv && bready) m_bv = 0;
            if (awvalid && m_awr) begin m_awh = 1; m_awa = awaddr; end
            if (wvalid && m_wr) begin
                m_wh = 1; m_wd = wdata; m_ws = wstrb;
            end
            if (m_awh && m_wh) begin
                m_idx = idx_of(m_awa);
                if (m_idx != 0 && m_idx < NR) begin
                    for (int b = 0; b < 4; b++)
                        if (m_ws[b]) mreg[m_idx][8*b +: 8] = m_wd[8*b +: 8];
                    if (m_ws != 0) m_pulse[m_idx] = 1'b1;
                end
                m_bv = 1;
                m_br = !DECERR ? 2'b00 :
                       (m_idx >= NR) ? 2'b11 :
                       (m_idx == 0) ? 2'b10 : 2'b00;
                m_awh = 0; m_wh = 0;
            end
            m_on = 1;
        end
    end

    logic [NR*DW-1:0] exp_regs;
    initial forever begin
        @(negedge aclk);
        if (chk_en) begin
            for (int i = 0; i < NR; i++)
                exp_regs[i*DW +: DW] = (i == 0) ? IDV : mreg[i];
            chk("regs", regs, exp_regs);
            chk("pulse", pulse, m_pulse);
            chk("awready", awready, m_on && !m_awh && !m_bv);
            chk("wready", wready, m_on && !m_wh && !m_bv);
            chk("arready", arready, m_on && !m_rv);
            chk("bvalid", bvalid, m_bv);
            chk("bresp", bresp, m_br);
            chk("rvalid", rvalid, m_rv);
            chk("rdata", rdata, m_rd);
            chk("rresp", rresp, m_rr);
        end
    end

    task automatic settle();
        @(posedge aclk); #1;
    endtask

    task automatic cyc(output bit a, output bit w, output bit r);
        bit sa, sw, sr;
        @(negedge aclk);
        sa = awready; sw = wready; sr = arready;
        @(posedge aclk);
        a = awvalid && sa; w = wvalid && sw; r = arvalid && sr;
        #1;
    endtask

    task automatic timeout(input string nm);
        n_checks++; n_fail++;
        $display("FAIL %s: got timeout expected handshake", nm);
    endtask

    task automatic do_write(input logic [31:0] ad, input logic [31:0] d,
                            input logic [3:0] s, input int awd_dly,
                            input int wd_dly);
        bit awd = 0, wd = 0, a, w, r;
        int c = 0;
        while (!(awd && wd) && c < 40) begin
            awvalid = !awd && c >= awd_dly; awaddr = ad;
            wvalid = !wd && c >= wd_dly; wdata = d; wstrb = s;
            cyc(a, w, r);
            if (a) awd = 1;
            if (w) wd = 1;
            c++;
        end
        awvalid = 0; wvalid = 0;
        if (!(awd && wd)) timeout("write");
    endtask

    task automatic do_read(input logic [31:0] ad, output logic [31:0] d,
                           output logic [1:0] rs);
        bit a, w, r, got = 0;
        int c = 0;
        d = 'x; rs = 'x;
        arvalid = 1; araddr = ad;
        r = 0;
        while (!r && c < 40) begin cyc(a, w, r); c++; end
        arvalid = 0;
        if (!r) timeout("ar");
        c = 0;
        while (!got && c < 40) begin
            @(negedge aclk);
            if (rvalid) begin got = 1; d = rdata; rs = rresp; end
            settle();
            c++;
        end
        if (!got) timeout("r");
    endtask

    function automatic logic [31:0] raddr();
        return BASE + 32'($urandom_range(0, NR + 1)) * 4
                    + 32'($urandom_range(0, 3));
    endfunction

    logic [31:0] d;
    logic [1:0]  rs;
    bit a, w, r;

    initial begin
        awaddr = 0; wdata = 0; araddr = 0; wstrb = 0;
        awprot = 0; arprot = 0;
        awvalid = 0; wvalid = 0; arvalid = 0;
        bready = 1; rready = 1;
        #2 rst = 1;
        #1 chk_en = 1;
        repeat (3) settle();
        rst = 0;
        @(negedge aclk);
        chk("rst_awready_low", awready, 0);
        chk("rst_rvalid_low", rvalid, 0);
        settle();
        @(negedge aclk);
        chk("awready_up", awready, 1);
        chk("arready_up", arready, 1);
        settle();

        do_write(BASE + 32'h0C, 32'hDEADBEEF, 4'hF, 0, 0);
        @(negedge aclk);
        chk("t1_bvalid", bvalid, 1);
        chk("t1_bresp", bresp, 2'b00);
        chk("t1_pulse", pulse, 16'h0008);
        chk("t1_reg3", regs[3*DW +: DW], 32'hDEADBEEF);
        settle();
        @(negedge aclk);
        chk("t1_pulse_off", pulse, 16'h0000);
        settle();
        do_read(BASE + 32'h0C, d, rs);
        chk("t1_readback", d, 32'hDEADBEEF);

        do_write(BASE + 32'h08, 32'h11223344, 4'h5, 2, 0);
        @(negedge aclk);
        chk("t2_reg2", regs[2*DW +: DW], 32'h00220044);
        settle();

        do_read(BASE, d, rs);
        chk("t3_id", d, 32'hA11E0001);
        do_write(BASE, 32'hFFFFFFFF, 4'hF, 0, 0);
        @(negedge aclk);
        chk("t3_bresp", bresp, DECERR ? 2'b10 : 2'b00);
        chk("t3_reg0", regs[DW-1:0], 32'hA11E0001);
        chk("t3_pulse", pulse, 16'h0000);
        settle();

        do_read(BASE + NR * 4, d, rs);
        chk("t4_rdata", d, 32'h0);
        chk("t4_rresp", rs, DECERR ? 2'b11 : 2'b00);
        do_write(BASE + NR * 4, 32'hCAFEF00D, 4'hF, 1, 0);
        @(negedge aclk);
        chk("t4_bresp", bresp, DECERR ? 2'b11 : 2'b00);
        chk("t4_reg3", regs[3*DW +: DW], 32'hDEADBEEF);
        chk("t4_reg2", regs[2*DW +: DW], 32'h00220044);
        settle();

        awvalid = 1; awaddr = BASE + 32'h14;
        wvalid = 1; wdata = 32'h12345678; wstrb = 4'hF;
        arvalid = 1; araddr = BASE + 32'h14;
        cyc(a, w, r);
        awvalid = 0; wvalid = 0; arvalid = 0;
        @(negedge aclk);
        chk("t5_old_value", rdata, 32'h0);
        chk("t5_reg5", regs[5*DW +: DW], 32'h12345678);
        settle();
        settle();

        bready = 0; rready = 0;
        awvalid = 1; awaddr = BASE + 32'h1C;
        wvalid = 1; wdata = 32'h0BADF00D; wstrb = 4'hF;
        arvalid = 1; araddr = BASE + 32'h0C;
        cyc(a, w, r);
        awvalid = 0; wvalid = 0; arvalid = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge aclk);
            chk("t6_bvalid", bvalid, 1);
            chk("t6_rvalid", rvalid, 1);
            chk("t6_rdata", rdata, 32'hDEADBEEF);
            chk("t6_ready", {awready, wready, arready}, 3'b000);
            settle();
        end
        bready = 1; rready = 1;
        settle();
        @(negedge aclk);
        chk("t6_released", {bvalid, rvalid}, 2'b00);
        settle();

        awvalid = 1; awaddr = BASE + 32'h10;
        arvalid = 1; araddr = BASE + 32'h0C;
        rready = 0;
        cyc(a, w, r);
        awvalid = 0; arvalid = 0;
        @(negedge aclk);
        chk("t7_rvalid_pend", rvalid, 1);
        settle();
        rst = 1;
        settle();
        @(negedge aclk);
        chk("t7_valids", {bvalid, rvalid}, 2'b00);
        chk("t7_reg3", regs[3*DW +: DW], 32'h0);
        chk("t7_readies", {awready, wready, arready}, 3'b000);
        settle();
        rst = 0; rready = 1;
        wvalid = 1; wdata = 32'h00000055; wstrb = 4'hF;
        for (int k = 0; k < 4; k++) begin
            cyc(a, w, r);
            if (w) wvalid = 0;
        end
        wvalid = 0;
        @(negedge aclk);
        chk("t7_no_b", bvalid, 0);
        settle();
        awvalid = 1; awaddr = BASE + 32'h10;
        r = 0;
        for (int k = 0; k < 4 && !r; k++) begin
            cyc(a, w, r);
            if (a) begin awvalid = 0; r = 1; end
        end
        awvalid = 0;
        @(negedge aclk);
        chk("t7_reg4", regs[4*DW +: DW], 32'h00000055);
        settle();

        for (int n = 0; n < 3000; n++) begin
            if (!awvalid && $urandom_range(0, 2) == 0) begin
                awvalid = 1; awaddr = raddr();
            end
            if (!wvalid && $urandom_range(0, 2) == 0) begin
                wvalid = 1; wdata = $urandom;
                wstrb = 4'($urandom_range(0, 15));
            end
            if (!arvalid && $urandom_range(0, 2) == 0) begin
                arvalid = 1; araddr = raddr();
            end
            bready = $urandom_range(0, 3) != 0;
            rready = $urandom_range(0, 3) != 0;
            if ($urandom_range(0, 599) == 0) begin
                rst = 1; awvalid = 0; wvalid = 0; arvalid = 0;
                settle(); settle();
                rst = 0;
            end
            cyc(a, w, r);
            if (a) awvalid = 0;
            if (w) wvalid = 0;
            if (r) arvalid = 0;
        end
        awvalid = 0; wvalid = 0; arvalid = 0;
        bready = 1; rready = 1;
        repeat (4) settle();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axi4lite_regfile.md
# axi4lite_regfile

AXI4-Lite slave register file that terminates the master port of the AXI4-Lite register station and provides NUM_REGS software-visible 32-bit control/status registers to the surrounding logic. It accepts AW and W independently, commits byte-enabled writes, returns B and R responses with registered handshakes, and exposes register contents and per-register write strobes to hardware. Register 0 is a read-only identification word.

## Interface
- ADDR_WIDTH, 32, AXI address width
- DATA_WIDTH, 32, AXI data width (32 or 64)
- NUM_REGS, 16, number of registers including ID register (2..256)
- BASE_ADDR, 0, byte address of register 0; must be aligned to NUM_REGS*DATA_WIDTH/8
- ID_VALUE, 32'hA11E_0001, constant returned by register 0
- RESET_VALUE, 0, reset value of registers 1..NUM_REGS-1

- aclk  in  1  clock
- aresetn  in  1  reset, asynchronous, active-high
- s_axi_awaddr/awprot/awvalid/awready  in/in/in/out  ADDR_WIDTH/3/1/1  write address channel
- s_axi_wdata/wstrb/wvalid/wready  in/in/in/out  DATA_WIDTH/DATA_WIDTH/8/1/1  write data channel
- s_axi_bresp/bvalid/bready  out/out/in  2/1/1  write response channel
- s_axi_araddr/arprot/arvalid/arready  in/in/in/out  ADDR_WIDTH/3/1/1  read address channel
- s_axi_rdata/rresp/rvalid/rready  out/out/out/in  DATA_WIDTH/2/1/1  read data channel
- regs_o  out  NUM_REGS*DATA_WIDTH  flat register contents, reg i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- wr_pulse_o  out  NUM_REGS  one-cycle pulse when reg i is written with non-zero wstrb

## Operation
- Word index = (addr - BASE_ADDR) >> log2(DATA_WIDTH/8); low address bits ignored (alignment is checked upstream). prot ignored.
- In range: index < NUM_REGS. Otherwise out of range.
- Write path: AW and W each captured into a holding register on handshake; awready = !aw_held && !bvalid, wready = !w_held && !bvalid (registered). Either channel may arrive first or both together.
- Commit when address and data both held (or handshaking this cycle): bytes with wstrb[b]=1 update target reg; reg 0 and out-of-range writes leave all registers unchanged. Holding registers cleared, bvalid set, bresp per Configuration.
- bvalid held until bready; awready/wready return high at the edge after the B handshake.
- Read path: arready = !rvalid. On AR handshake rdata = reg value (ID_VALUE for index 0, 0 if out of range), rresp set, rvalid set. rvalid/rdata/rresp held stable until rready.
- Simultaneous read and write commit on same register: read returns pre-write value.
- wr_pulse_o[i] high for exactly the cycle after commit to reg i with wstrb != 0; never for reg 0.
- Reset (aresetn=1): all pending transactions discarded; registers to RESET_VALUE; awready=wready=arready=0, bvalid=rvalid=0, bresp=rresp=0, rdata=0, wr_pulse_o=0. Readies go to 1 on the first edge after aresetn falls.

## Timing
- Write latency: bvalid high 1 cycle after the later of AW/W handshake; regs_o reflects new value in the same cycle as bvalid.
- Read latency: rvalid 1 cycle after AR handshake.
- Throughput: one write per 2 cycles with bready held high; one read per 2 cycles with rready held high.
- Read and write paths independent; no ordering between them.
- No combinational path from any input to any output.

## Configuration
- AXIL_REGFILE_DECERR_EN defined: out-of-range reads and writes respond DECERR (2'b11); writes to reg 0 respond SLVERR (2'b10).
- Undefined: all responses OKAY (2'b00); out-of-range reads return 0, writes silently dropped.

## Test plan
- Reset release, write 0xDEADBEEF to reg 3 (addr BASE+0x0C, wstrb 0xF), AW and W same cycle -> bvalid 1 cycle later, bresp 0, wr_pulse_o[3] one cycle, read back 0xDEADBEEF.
- W two cycles before AW, data 0x11223344 wstrb 0x5 to reg 2 (was 0) -> reg 2 = 0x00220044, B only after AW handshake.
- Read addr BASE+0x00 -> rdata ID_VALUE; write 0xFFFFFFFF there -> reg unchanged, bresp 2'b10 with macro, 2'b00 without.
- Read/write BASE+NUM_REGS*4 -> rdata 0, resp 2'b11 with macro, 2'b00 without; regs_o unchanged.
- bready/rready held low 5 cycles -> bvalid/rvalid/rdata stable, awready/wready/arready stay 0 until handshake.
- Assert aresetn with AW held and rvalid pending -> all valids 0, regs RESET_VALUE, no B issued after release.
